// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the round-robin bus lane controller.
// Holds the FSM state encoding, the default broadcast ID and the header decode.
package bus_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } ctrl_state_e;

    localparam logic [7:0] BROADCAST_ID = 8'hFF;
    localparam int         PKT_MAX_W    = 64;

    // Destination ID sits in the top id_w bits of the packet.
    function automatic logic [31:0] get_dst(input logic [PKT_MAX_W-1:0] pkt,
                                            input int                  pkt_w,
                                            input int                  id_w);
        logic [PKT_MAX_W-1:0] sh;
        sh = pkt >> (pkt_w - id_w);
        return sh[31:0] & ((32'h1 << id_w) - 32'h1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last grant
// and wraps, so every requester is reached within N grants.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any_req
);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(last_grant) + i) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_rr_ctrl.sv
// Single-lane bus controller: round-robin grant, pop the winner's head packet,
// then deliver it to the addressed terminal (or all others on broadcast).
module bus_rr_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter int               pckg_sz   = 16,
    parameter int               drvrs     = 4,
    parameter int               id_w      = 8,
    parameter logic [id_w-1:0]  broadcast = BROADCAST_ID
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [drvrs-1:0]                   pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]      D_pop,
    output logic [drvrs-1:0]                   pop,
    output logic [drvrs-1:0]                   push,
    output logic [drvrs-1:0][pckg_sz-1:0]      D_push,
    output logic                               busy,
    output logic [$clog2(drvrs)-1:0]           grant_id,
    output logic [7:0]                         drop_cnt
);

    localparam int GID_W = $clog2(drvrs);

    ctrl_state_e                    state_q, state_d;
    logic [GID_W-1:0]               grant_q, grant_d;
    logic [GID_W-1:0]               last_grant_q, last_grant_d;
    logic [pckg_sz-1:0]             pkt_q, pkt_d;
    logic [drvrs-1:0]               pop_q, pop_d;
    logic [drvrs-1:0]               push_q, push_d;
    logic [drvrs-1:0][pckg_sz-1:0]  d_push_q, d_push_d;
    logic                           busy_q, busy_d;
    logic [7:0]                     drop_q, drop_d;
    logic [id_w-1:0]                dst;

    logic [drvrs-1:0]               arb_gnt;
    logic [GID_W-1:0]               arb_idx;
    logic                           arb_any;

    rr_arbiter #(
        .N     (drvrs),
        .IDX_W (GID_W)
    ) u_arb (
        .req        (pndng),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .any_req    (arb_any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_d        = pkt_q;
        pop_d        = '0;
        push_d       = '0;
        d_push_d     = d_push_q;
        drop_d       = drop_q;
        dst          = '0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d = POP;
                    grant_d = arb_idx;
                    pkt_d   = D_pop[arb_idx];
                    pop_d   = arb_gnt;
                end
            end
            POP: begin
                // Delivery strobes are decided here so they appear registered in PUSH.
                state_d  = PUSH;
                dst      = id_w'(get_dst(PKT_MAX_W'(pkt_q), pckg_sz, id_w));
                d_push_d = {drvrs{pkt_q}};
                if (dst == broadcast) begin
                    push_d          = '1;
                    push_d[grant_q] = 1'b0;
                end else if (int'(dst) < drvrs && int'(dst) != int'(grant_q)) begin
                    push_d[GID_W'(dst)] = 1'b1;
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
            PUSH: begin
                state_d      = IDLE;
                last_grant_d = grant_q;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GID_W'(drvrs - 1);
            pop_q        <= '0;
            push_q       <= '0;
            d_push_q     <= '0;
            busy_q       <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pop_q        <= pop_d;
            push_q       <= push_d;
            d_push_q     <= d_push_d;
            busy_q       <= busy_d;
            drop_q       <= drop_d;
        end
    end

    always_ff @(posedge clock) begin
        pkt_q <= pkt_d;
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = d_push_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rr_ctrl.sv
// Directed bench for bus_rr_ctrl with hand-computed expectations.
module tb_bus_rr_ctrl;

    logic              clock;
    logic              reset;
    logic [3:0]        pndng;
    logic [3:0][15:0]  d_pop;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic [3:0][15:0]  d_push;
    logic              busy;
    logic [1:0]        grant_id;
    logic [7:0]        drop_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    bus_rr_ctrl #(
        .pckg_sz   (16),
        .drvrs     (4),
        .id_w      (8),
        .broadcast (8'hFF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .busy     (busy),
        .grant_id (grant_id),
        .drop_cnt (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_pop",   32'(pop), 0);
        check("rst_push",  32'(push), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_gid",   32'(grant_id), 0);
        check("rst_drop",  32'(drop_cnt), 0);
        check("rst_dpush", 32'(d_push[2]), 0);

        // Unicast 0 -> 2, head changed after capture must not matter
        pndng    = 4'b0001;
        d_pop[0] = 16'h02AB;
        tick();
        check("uc_pop",  32'(pop), 32'h1);
        check("uc_busy", 32'(busy), 1);
        check("uc_gid",  32'(grant_id), 0);
        pndng    = 4'b0000;
        d_pop[0] = 16'h0000;
        tick();
        check("uc_push",  32'(push), 32'h4);
        check("uc_dpush", 32'(d_push[2]), 32'h02AB);
        check("uc_pop0",  32'(pop), 0);
        check("uc_drop",  32'(drop_cnt), 0);
        tick();
        check("uc_push_end", 32'(push), 0);
        check("uc_idle",     32'(busy), 0);

        // Round robin from reset: all pending, each addressed to the next terminal
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d_pop[0] = 16'h0100;
        d_pop[1] = 16'h0201;
        d_pop[2] = 16'h0302;
        d_pop[3] = 16'h0003;
        pndng    = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_pop%0d", k), 32'(pop), 32'(1) << (k % 4));
            check($sformatf("rr_gid%0d", k), 32'(grant_id), 32'(k % 4));
            check($sformatf("rr_one%0d", k), 32'($countones(pop)), 1);
            tick();
            check($sformatf("rr_push%0d", k), 32'(push), 32'(1) << ((k + 1) % 4));
            check($sformatf("rr_nopop%0d", k), 32'(pop), 0);
            tick();
            check($sformatf("rr_gap%0d", k), 32'(pop | push), 0);
            if (k == 4) pndng = 4'b0000;
        end

        // Broadcast from terminal 1 (last grant was 0)
        d_pop[1] = 16'hFF55;
        pndng    = 4'b0010;
        tick();
        check("bc_pop", 32'(pop), 32'h2);
        pndng = 4'b0000;
        tick();
        check("bc_push", 32'(push), 32'hD);
        for (int d = 0; d < 4; d++)
            check($sformatf("bc_lane%0d", d), 32'(d_push[d]), 32'hFF55);
        tick();

        // Reset during POP: last_grant returns to 3 so terminal 0 wins next
        d_pop[0] = 16'h0100;
        pndng    = 4'b0001;
        tick();
        check("rp_pop0", 32'(pop), 32'h1);
        pndng = 4'b0000;
        tick();
        check("rp_push0", 32'(push), 32'h2);
        tick();
        d_pop[1] = 16'h0011;
        pndng    = 4'b0010;
        tick();
        check("rp_pop1", 32'(pop), 32'h2);
        pndng = 4'b0000;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rp_pop_sup",  32'(pop), 0);
        check("rp_push_sup", 32'(push), 0);
        check("rp_busy",     32'(busy), 0);
        check("rp_drop",     32'(drop_cnt), 0);
        pndng = 4'b0011;
        tick();
        check("rp_gid", 32'(grant_id), 0);
        check("rp_pop", 32'(pop), 32'h1);
        pndng = 4'b0000;
        tick();
        check("rp_push", 32'(push), 32'h2);
        tick();

        // Out-of-range then self-addressed: pops, no pushes, two drops
        d_pop[2] = 16'h0711;
        pndng    = 4'b0100;
        tick();
        check("dr_pop2", 32'(pop), 32'h4);
        pndng = 4'b0000;
        tick();
        check("dr_push2", 32'(push), 0);
        check("dr_cnt1",  32'(drop_cnt), 1);
        tick();
        d_pop[3] = 16'h0300;
        pndng    = 4'b1000;
        tick();
        check("dr_pop3", 32'(pop), 32'h8);
        pndng = 4'b0000;
        tick();
        check("dr_push3", 32'(push), 0);
        check("dr_cnt2",  32'(drop_cnt), 2);
        tick();

        // 300 invalid packets from terminal 2: counter saturates
        pndng = 4'b0100;
        for (int i = 0; i < 300; i++) begin
            tick();
            tick();
            tick();
            if (i == 251) check("sat_254", 32'(drop_cnt), 254);
            if (i == 299) pndng = 4'b0000;
        end
        tick();
        check("sat_255", 32'(drop_cnt), 255);
        check("sat_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bus_rr_ctrl.md
# bus_rr_ctrl

Central controller for one lane of the parallel parametrizable bus. It owns the shared bus medium: it arbitrates round-robin among `drvrs` terminals with pending packets and pops the granted packet. It then decodes the destination ID from the packet header and pushes the packet to the addressed terminal, or to every other terminal on broadcast. One instance serves one bus; multi-bus configurations (`bits` > 1) instantiate one controller per bus.

## Interface
Parameters:
- `pckg_sz`, 16, packet width in bits; must be ≥ `id_w` + 1.
- `drvrs`, 4, number of terminals on the bus (2..16).
- `id_w`, 8, width of the destination-ID field, `D_pop[pckg_sz-1 -: id_w]`.
- `broadcast`, 8'hFF, destination ID meaning "all terminals except source".

Ports:
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `pndng`  in  [drvrs-1:0]  terminal d has at least one packet queued.
- `D_pop`  in  [drvrs-1:0][pckg_sz-1:0]  head-of-queue packet of terminal d; valid while `pndng[d]`.
- `pop`  out  [drvrs-1:0]  one-cycle consume strobe to terminal d.
- `push`  out  [drvrs-1:0]  one-cycle deliver strobe to terminal d.
- `D_push`  out  [drvrs-1:0][pckg_sz-1:0]  delivered packet; identical on all lanes, valid with `push`.
- `busy`  out  1  a transfer is in flight (state ≠ IDLE).
- `grant_id`  out  $clog2(drvrs)  terminal granted in the current or most recent transfer.
- `drop_cnt`  out  8  packets dropped; saturates at 255.

## Operation
- FSM states: IDLE, POP, PUSH.
- IDLE: if any `pndng` bit is set, select the winner by round-robin. The search starts at `last_grant+1` mod `drvrs`. Latch the winner into `grant_id` and latch `D_pop[winner]` into `pkt_q`. Go to POP. If no bit is set, stay in IDLE.
- POP: assert `pop[grant_id]` for exactly this cycle. Decode `dst = pkt_q[pckg_sz-1 -: id_w]` and go to PUSH.
- PUSH: drive `D_push[*] = pkt_q`.
  - If `dst == broadcast`, assert `push[d]` for every d ≠ `grant_id`.
  - Else if `dst < drvrs` and `dst != grant_id`, assert `push[dst]` only.
  - Otherwise (out-of-range or self-addressed), assert no `push` and increment `drop_cnt`.
  - Update `last_grant = grant_id` and return to IDLE.
- Packets are never modified. Exactly one packet is in flight at any time.
- Fairness: a terminal with `pndng` held high is granted within `drvrs` transfers.

## Timing
- All outputs are registered.
- Reset values: `pop`=0, `push`=0, `D_push`=0, `busy`=0, `grant_id`=0, `drop_cnt`=0. Internally, `last_grant`=`drvrs-1` (terminal 0 wins first) and state = IDLE.
- Latency: `pndng` sampled at edge N → `pop` high in cycle N+1 → `push` high in cycle N+2.
- Throughput: one packet per 3 cycles under continuous load; IDLE is re-entered after every transfer.
- Data is captured at the arbitration edge. A `D_pop` change after capture does not affect delivery.
- `pndng[grant_id]` falling while in POP/PUSH: `pop` is still issued and the packet is still delivered. Terminals must not withdraw the head packet.
- Simultaneous requests: resolved purely by round-robin order; no fixed priority.
- `reset` asserted in any state: outputs take reset values at that edge, so any in-flight `pop`/`push` is suppressed. A packet already popped but not pushed is lost; this is acceptable and is not counted.
- `drop_cnt` at 255 stays at 255.

## Structure
- Package `bus_ctrl_pkg`:
  - state enum `ctrl_state_e` {IDLE, POP, PUSH};
  - localparam default `BROADCAST_ID`;
  - function `get_dst(pkt)` returning the ID field.
- Sub-module `rr_arbiter #(N)`:
  - inputs: request vector, `last_grant`;
  - outputs: one-hot grant, encoded index, `any_req`;
  - purely combinational; the FSM registers its result.
- Top `bus_rr_ctrl`: FSM, packet register, delivery decode, drop counter.

## Test plan
- Reset, then `pndng`=4'b0001 with `D_pop[0]`=16'h02AB → `pop[0]` at N+1; at N+2 `push`=4'b0100 and `D_push[2]`=16'h02AB; `drop_cnt`=0.
- All four `pndng` held high, each head addressed to the next terminal → grant order 0,1,2,3,0; one `pop` every 3 cycles; never two `pop` bits set at once.
- `D_pop[1]`=16'hFF55 (broadcast) → `push`=4'b1101 with `D_push`=16'hFF55 on all lanes.
- `D_pop[2]`=16'h0711 (dst 7 ≥ `drvrs`), then `D_pop[3]`=16'h0300 (self-addressed) → `pop` pulses occur, no `push`, `drop_cnt`=2.
- `reset` asserted in the POP cycle → next cycle `pop`=0 and `push`=0 and state is IDLE; `drop_cnt` unchanged; the next grant goes to terminal 0.
- 300 invalid-destination packets → `drop_cnt` saturates at 255.
